// File: rtl/adc_pkg.sv
// Shared constants, state encoding and frame-slicing helper for the SPI ADC capture stage.
package adc_pkg;

    localparam int unsigned FRAME_BITS = 34;
    localparam int unsigned CH_BITS    = 14;
    localparam int unsigned CHA_FIRST  = 2;
    localparam int unsigned CHB_FIRST  = 18;
    localparam int unsigned IDX_W      = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_SHIFT,
        ST_DONE
    } state_e;

    // Bit index i of the frame lands at shift-register position FRAME_BITS-1-i.
    function automatic logic [CH_BITS-1:0] frame_channel(input logic [FRAME_BITS-1:0] frame,
                                                         input int unsigned first);
        return CH_BITS'(frame >> (FRAME_BITS - first - CH_BITS));
    endfunction

endpackage

// File: rtl/adc_spi_capture_bit_timer.sv
// SPI bit timer: per-bit cycle counter driving spi_sck, the mid-bit sample tick and end-of-bit.
module spi_bit_timer #(
    parameter int unsigned BIT_CYCLES = 2,
    parameter int unsigned CNT_W      = 1
) (
    input  logic clock,
    input  logic resetn,
    input  logic active_i,
    input  logic run_next_i,
    output logic spi_sck_o,
    output logic sample_tick_c,
    output logic bit_end_c
);

    localparam int unsigned HALF = BIT_CYCLES / 2;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sck_q, sck_d;

    // cnt_q is the position inside the current bit; sck is registered from the next position.
    always_comb begin
        sample_tick_c = active_i && (cnt_q == CNT_W'(HALF - 1));
        bit_end_c     = active_i && (cnt_q == CNT_W'(BIT_CYCLES - 1));
        cnt_d         = '0;
        if (active_i && !bit_end_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        sck_d = run_next_i && (cnt_d < CNT_W'(HALF));
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign spi_sck_o = sck_q;

endmodule

// File: rtl/adc_spi_capture.sv
// Two-channel 14-bit SPI ADC capture: trigger edge detect, frame FSM, 34-bit deserialiser.
// Build option ADC_OFFSET_BINARY_EN: invert each channel MSB at load (offset-binary output).
module adc_spi_capture
    import adc_pkg::*;
#(
    parameter int unsigned BIT_CYCLES  = 2,
    parameter int unsigned CONV_CYCLES = 1
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               enableadc,
    input  logic               spi_miso,
    output logic               ad_conv,
    output logic               spi_sck,
    output logic [CH_BITS-1:0] sample_a,
    output logic [CH_BITS-1:0] sample_b,
    output logic               sample_valid,
    output logic               busy
);

    localparam int unsigned CNT_MAX = (BIT_CYCLES > CONV_CYCLES) ? BIT_CYCLES : CONV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    state_e                  state_q, state_d;
    logic                    en_q;
    logic [CNT_W-1:0]        conv_cnt_q, conv_cnt_d;
    logic [IDX_W-1:0]        bit_idx_q, bit_idx_d;
    logic [FRAME_BITS-1:0]   sr_q, sr_d;
    logic [CH_BITS-1:0]      sample_a_q, sample_a_d, sample_b_q, sample_b_d;
    logic                    ad_conv_q, ad_conv_d, valid_q, valid_d, busy_q, busy_d;
    logic [CH_BITS-1:0]      ch_a_c, ch_b_c;
    logic                    start_c, sample_tick_c, bit_end_c;

    spi_bit_timer #(
        .BIT_CYCLES(BIT_CYCLES),
        .CNT_W     (CNT_W)
    ) u_bit_timer (
        .clock        (clock),
        .resetn       (resetn),
        .active_i     (state_q == ST_SHIFT),
        .run_next_i   (state_d == ST_SHIFT),
        .spi_sck_o    (spi_sck),
        .sample_tick_c(sample_tick_c),
        .bit_end_c    (bit_end_c)
    );

    // Gap bits are discarded simply by never being sliced out of the shift register.
    always_comb begin
        ch_a_c = frame_channel(sr_q, CHA_FIRST);
        ch_b_c = frame_channel(sr_q, CHB_FIRST);
`ifdef ADC_OFFSET_BINARY_EN
        ch_a_c[CH_BITS-1] = ~ch_a_c[CH_BITS-1];
        ch_b_c[CH_BITS-1] = ~ch_b_c[CH_BITS-1];
`endif
    end

    assign start_c = enableadc && !en_q && (state_q == ST_IDLE);

    always_comb begin
        state_d    = state_q;
        conv_cnt_d = conv_cnt_q;
        bit_idx_d  = bit_idx_q;
        sr_d       = sr_q;
        sample_a_d = sample_a_q;
        sample_b_d = sample_b_q;
        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    state_d    = ST_CONV;
                    conv_cnt_d = '0;
                end
            end
            ST_CONV: begin
                if (conv_cnt_q == CNT_W'(CONV_CYCLES - 1)) begin
                    state_d   = ST_SHIFT;
                    bit_idx_d = '0;
                end else begin
                    conv_cnt_d = conv_cnt_q + CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (sample_tick_c) begin
                    sr_d = {sr_q[FRAME_BITS-2:0], spi_miso};
                end
                if (bit_end_c) begin
                    if (bit_idx_q == IDX_W'(FRAME_BITS - 1)) begin
                        state_d    = ST_DONE;
                        sample_a_d = ch_a_c;
                        sample_b_d = ch_b_c;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ad_conv_d = (state_d == ST_CONV);
        valid_d   = (state_d == ST_DONE);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            en_q       <= 1'b0;
            conv_cnt_q <= '0;
            bit_idx_q  <= '0;
            sr_q       <= '0;
            sample_a_q <= '0;
            sample_b_q <= '0;
            ad_conv_q  <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= enableadc;
            conv_cnt_q <= conv_cnt_d;
            bit_idx_q  <= bit_idx_d;
            sr_q       <= sr_d;
            sample_a_q <= sample_a_d;
            sample_b_q <= sample_b_d;
            ad_conv_q  <= ad_conv_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign ad_conv      = ad_conv_q;
    assign sample_a     = sample_a_q;
    assign sample_b     = sample_b_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_adc_spi_capture.sv
// Directed self-checking bench for adc_spi_capture: BIT_CYCLES=2 and BIT_CYCLES=4 instances.
module tb_adc_spi_capture;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        en2 = 1'b0, en4 = 1'b0;
    logic        tog = 1'b0, rst_phase = 1'b1;
    logic        miso_m2 = 1'b0, miso_m4 = 1'b0;
    logic        miso2, miso4;
    logic        adconv2, sck2, valid2, busy2;
    logic        adconv4, sck4, valid4, busy4;
    logic [13:0] a2, b2, a4, b4;
    logic [33:0] frame2 = '0, frame4 = '0;
    int          sck_cnt2 = 0, sck_cnt4 = 0, base2 = 0, base4 = 0;
    int          checks = 0, errors = 0;
    logic [13:0] cap_a, cap_b;
    int          lat, nv, np, nc;

    always #5 clk = ~clk;

    assign miso2 = rst_phase ? tog : miso_m2;
    assign miso4 = rst_phase ? tog : miso_m4;

    adc_spi_capture #(.BIT_CYCLES(2), .CONV_CYCLES(1)) u_dut2 (
        .clock(clk), .resetn(resetn), .enableadc(en2), .spi_miso(miso2),
        .ad_conv(adconv2), .spi_sck(sck2), .sample_a(a2), .sample_b(b2),
        .sample_valid(valid2), .busy(busy2)
    );

    adc_spi_capture #(.BIT_CYCLES(4), .CONV_CYCLES(1)) u_dut4 (
        .clock(clk), .resetn(resetn), .enableadc(en4), .spi_miso(miso4),
        .ad_conv(adconv4), .spi_sck(sck4), .sample_a(a4), .sample_b(b4),
        .sample_valid(valid4), .busy(busy4)
    );

    // ADC model: presents frame bit k after the k-th rising spi_sck of the frame.
    always @(posedge sck2) begin
        int k;
        k = sck_cnt2 - base2;
        miso_m2 = (k >= 0 && k < 34) ? frame2[33-k] : 1'b0;
        sck_cnt2++;
    end

    always @(posedge sck4) begin
        int k;
        k = sck_cnt4 - base4;
        miso_m4 = (k >= 0 && k < 34) ? frame4[33-k] : 1'b0;
        sck_cnt4++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] exp_ch(input logic [13:0] v);
`ifdef ADC_OFFSET_BINARY_EN
        return {~v[13], v[12:0]};
`else
        return v;
`endif
    endfunction

    // Raise enableadc, count edges until sample_valid; optional drop/re-raise of enableadc.
    task automatic run_frame(input int sel, input logic [13:0] a, input logic [13:0] b,
                             input logic gap, input int drop_at, input int rise_at,
                             input int budget, output int lat_o, output int nv_o,
                             output int np_o, output int nc_o);
        logic [33:0] fw;
        logic        v, c;
        fw = {gap, gap, a, gap, gap, b, gap, gap};
        lat_o = -1; nv_o = 0; nc_o = 0;
        if (sel == 0) begin frame2 = fw; base2 = sck_cnt2; en2 = 1'b1; end
        else          begin frame4 = fw; base4 = sck_cnt4; en4 = 1'b1; end
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk);
            #1;
            if (n == drop_at) begin if (sel == 0) en2 = 1'b0; else en4 = 1'b0; end
            if (n == rise_at) begin if (sel == 0) en2 = 1'b1; else en4 = 1'b1; end
            v = (sel == 0) ? valid2 : valid4;
            c = (sel == 0) ? adconv2 : adconv4;
            if (c) nc_o++;
            if (v) begin
                nv_o++;
                if (lat_o < 0) begin
                    lat_o = n;
                    cap_a = (sel == 0) ? a2 : a4;
                    cap_b = (sel == 0) ? b2 : b4;
                end
            end
        end
        en2 = 1'b0;
        en4 = 1'b0;
        np_o = (sel == 0) ? (sck_cnt2 - base2) : (sck_cnt4 - base4);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with MISO toggling
        repeat (3) begin
            @(posedge clk);
            #1;
            tog = ~tog;
        end
        check("rst_out2", {adconv2, sck2, a2, b2, valid2, busy2}, 32'h0);
        check("rst_out4", {adconv4, sck4, a4, b4, valid4, busy4}, 32'h0);
        check("rst_sck_edges", 32'(sck_cnt2 + sck_cnt4), 32'h0);
        resetn = 1'b1;
        rst_phase = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic frame
        run_frame(0, 14'h2AAA, 14'h1555, 1'b1, -1, -1, 80, lat, nv, np, nc);
        check("f1_latency", 32'(lat), 32'd70);
        check("f1_valid_cnt", 32'(nv), 32'd1);
        check("f1_sck_pulses", 32'(np), 32'd34);
        check("f1_conv_cnt", 32'(nc), 32'd1);
        check("f1_a", 32'(cap_a), 32'(exp_ch(14'h2AAA)));
        check("f1_b", 32'(cap_b), 32'(exp_ch(14'h1555)));
        repeat (5) @(posedge clk);
        #1;
        check("f1_hold_a", 32'(a2), 32'(exp_ch(14'h2AAA)));
        check("f1_idle_sck_busy", {30'h0, sck2, busy2}, 32'h0);

        // Gap bits high must not leak into zero channels
        run_frame(0, 14'h0000, 14'h0000, 1'b1, -1, -1, 80, lat, nv, np, nc);
        check("gap1_a", 32'(cap_a), 32'(exp_ch(14'h0000)));
        check("gap1_b", 32'(cap_b), 32'(exp_ch(14'h0000)));

        // Extremes with gap bits low
        run_frame(0, 14'h2000, 14'h1FFF, 1'b0, -1, -1, 80, lat, nv, np, nc);
        check("gap0_a", 32'(cap_a), 32'(exp_ch(14'h2000)));
        check("gap0_b", 32'(cap_b), 32'(exp_ch(14'h1FFF)));

        // Level held high for 200 cycles: one frame only
        run_frame(0, 14'h1234, 14'h0ABC, 1'b1, -1, -1, 200, lat, nv, np, nc);
        check("hold_valid_cnt", 32'(nv), 32'd1);
        check("hold_latency", 32'(lat), 32'd70);
        check("hold_a", 32'(cap_a), 32'(exp_ch(14'h1234)));

        // Drop enableadc at cycle 20: frame still completes
        run_frame(0, 14'h3C3C, 14'h0F0F, 1'b0, 20, -1, 80, lat, nv, np, nc);
        check("drop_latency", 32'(lat), 32'd70);
        check("drop_b", 32'(cap_b), 32'(exp_ch(14'h0F0F)));

        // Second edge at cycle 30 ignored, not queued
        run_frame(0, 14'h1111, 14'h2222, 1'b1, 10, 30, 150, lat, nv, np, nc);
        check("retrig_latency", 32'(lat), 32'd70);
        check("retrig_valid_cnt", 32'(nv), 32'd1);
        run_frame(0, 14'h0555, 14'h3AAA, 1'b0, -1, -1, 80, lat, nv, np, nc);
        check("next_latency", 32'(lat), 32'd70);
        check("next_a", 32'(cap_a), 32'(exp_ch(14'h0555)));
        check("next_b", 32'(cap_b), 32'(exp_ch(14'h3AAA)));

        // Reset at cycle 40 of a frame aborts it
        frame2 = {2'b11, 14'h2AAA, 2'b11, 14'h1555, 2'b11};
        base2 = sck_cnt2;
        en2 = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        resetn = 1'b0;
        en2 = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_out", {adconv2, sck2, a2, b2, valid2, busy2}, 32'h0);
        resetn = 1'b1;
        nv = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (valid2) nv++;
        end
        check("midrst_no_valid", 32'(nv), 32'd0);
        run_frame(0, 14'h0F0F, 14'h30F0, 1'b1, -1, -1, 80, lat, nv, np, nc);
        check("postrst_latency", 32'(lat), 32'd70);
        check("postrst_a", 32'(cap_a), 32'(exp_ch(14'h0F0F)));
        check("postrst_b", 32'(cap_b), 32'(exp_ch(14'h30F0)));

        // BIT_CYCLES=4 instance
        run_frame(1, 14'h0001, 14'h3FFF, 1'b1, -1, -1, 145, lat, nv, np, nc);
        check("b4_latency", 32'(lat), 32'd138);
        check("b4_valid_cnt", 32'(nv), 32'd1);
        check("b4_sck_pulses", 32'(np), 32'd34);
        check("b4_a", 32'(cap_a), 32'(exp_ch(14'h0001)));
        check("b4_b", 32'(cap_b), 32'(exp_ch(14'h3FFF)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
